mips_hazard_unit: RTL and testbench
===================================

Name: mips_hazard_unit

Overview:
Parametrised hazard and forwarding controller for the pipelined MIPS datapath. It tracks destination registers through a configurable number of post-ID stages. From that it generates load-use stalls and registered forwarding selects for the EX stage, and handles branch flush. A RUN/DRAIN/HALTED state machine retires in-flight instructions after the all-ones halt instruction. It sits beside the ID stage and is driven by the decoded IF/ID instruction and the main control signals.

Parameters:
REG_ADDR_W, 5, register-number width
PIPE_DEPTH, 3, tracked post-ID slots (slot 1 = EX ... slot PIPE_DEPTH = WB); legal range 2..15
LOAD_AVAIL, 3, lowest slot index whose output holds loaded data; legal range 2..PIPE_DEPTH
CNT_W, 16, statistics counter width
SEL_W (localparam), $clog2(PIPE_DEPTH+1), forwarding-select width

Ports:
clock  in  1  pipeline clock, rising edge
reset_n  in  1  asynchronous active-low reset
id_valid  in  1  IF/ID holds a real instruction
id_halt  in  1  IF/ID instruction is the all-ones halt word
id_rs  in  REG_ADDR_W  source register 1
id_rt  in  REG_ADDR_W  source register 2
id_uses_rt  in  1  rt is read as an operand (R-type, sw, beq)
id_dest  in  REG_ADDR_W  destination after RegDst selection
id_reg_write  in  1  RegWrite of the ID instruction
id_mem_read  in  1  MemRead of the ID instruction
flush  in  1  branch taken: kill the ID instruction and slot 1
stall  out  1  hold PC and IF/ID this cycle (combinational)
issue  out  1  ID instruction enters slot 1 at the next edge (combinational)
ex_fwd_rs_sel  out  SEL_W  registered; 0 = register file, k = result at output of slot k
ex_fwd_rt_sel  out  SEL_W  same, for rt
slot_valid  out  PIPE_DEPTH  bit k-1 = slot k occupied
halted  out  1  pipeline drained after halt
stall_count  out  CNT_W  saturating count of stall cycles
issue_count  out  CNT_W  saturating count of issued instructions

Behaviour:
- Reset (asynchronous, reset_n=0): all slots invalid, fwd sels 0, state RUN, halted 0, counters 0. A mid-DRAIN reset returns the block to RUN immediately.
- Slot record: {valid, dest, reg_write, mem_read}. Every edge, slot k moves to slot k+1 and the record in slot PIPE_DEPTH is dropped. The pipeline is never back-pressured downstream of ID.
- Slot 1 loads the ID record when issue=1. Otherwise slot 1 loads a bubble (valid=0).
- Match(r, k): slot k valid, reg_write=1, dest==r, r!=0. Only slots 1..PIPE_DEPTH-1 are checked. The slot PIPE_DEPTH (WB) case is covered by the write-before-read register file, which gives sel 0.
- Per operand, the youngest matching slot k wins (smallest k). Required sel = k+1.
- Load-use: the youngest match has mem_read=1 and k+1 < LOAD_AVAIL. The rt operand counts only if id_uses_rt=1.
- stall = id_valid & state==RUN & !flush & load-use(rs or rt).
- issue = id_valid & state==RUN & !flush & !stall & !id_halt.
- On issue, ex_fwd_*_sel register the computed sel. On a non-issue edge they register 0.
- Flush: slot 1 is invalidated at the next edge instead of shifting its record in. That record is discarded, so slot 2 receives a bubble. The ID instruction is not issued. Flush overrides stall, and the edge is not counted as a stall.
- FSM:
  - RUN to DRAIN: on id_valid & id_halt & !stall & !flush. A drain counter loads PIPE_DEPTH.
  - DRAIN: no issue; the counter decrements each edge. At 0 the state moves to HALTED.
  - HALTED: halted=1; the state persists until reset. id_* inputs are ignored in DRAIN and HALTED.
- Counters: stall_count increments on each edge with stall=1. issue_count increments on each edge with issue=1. Both saturate at 2^CNT_W-1 with no wrap.

Test Plan:
- Defaults. Issue lw $2 (dest 2, mem_read), then add $3,$2,$4 next cycle -> stall=1 for exactly 1 cycle. The add then issues with ex_fwd_rs_sel=3 and stall_count=1.
- Issue add $5,$1,$1, then sub $6,$5,$5 -> no stall. ex_fwd_rs_sel=2 and ex_fwd_rt_sel=2 in the cycle sub is in EX.
- Two producers to $7 in consecutive cycles, then a consumer of $7 -> sel=2 (youngest), never 3. Consumer of $0 after a write to $0 -> sel=0, no stall.
- Assert flush in the same cycle as a load-use condition -> stall=0, issue=0, slot 1 bubble next edge, stall_count unchanged.
- Present halt after 2 issued instructions -> issue stops. halted rises exactly PIPE_DEPTH+1 edges after halt is seen and slot_valid reaches 0. Pulse reset_n low mid-DRAIN -> immediate RUN with all outputs at reset values.
- PIPE_DEPTH=5, LOAD_AVAIL=4: load then dependent -> 2 stall cycles, then sel=4. CNT_W=2 with 5 stalls -> stall_count holds at 3.

Source files
------------

// File: rtl/mips_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : mips_hazard_unit
// Purpose  : Load-use stall, EX forwarding select, branch flush and halt drain
//            control for the pipelined MIPS datapath.
// Revision : 1.0
// ============================================================================
module mips_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int PIPE_DEPTH = 3,
  parameter int LOAD_AVAIL = 3,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic                  id_halt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic                  stall,
  output logic                  issue,
  output logic [SEL_W-1:0]      ex_fwd_rs_sel,
  output logic [SEL_W-1:0]      ex_fwd_rt_sel,
  output logic [PIPE_DEPTH-1:0] slot_valid,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      issue_count
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]            state;
  logic [1:0]            next_state;
  logic [SEL_W-1:0]      drain_cnt;
  logic                  running;

  logic [PIPE_DEPTH:1]   slot_v;
  logic [PIPE_DEPTH:1]   slot_rw;
  logic [PIPE_DEPTH:1]   slot_mr;
  logic [REG_ADDR_W-1:0] slot_dest [1:PIPE_DEPTH];

  logic [SEL_W-1:0]      rs_sel;
  logic [SEL_W-1:0]      rt_sel;
  logic                  rs_load_use;
  logic                  rt_load_use;

  // Scan oldest to youngest so the youngest matching slot is the one kept.
  always_comb begin
    rs_sel      = '0;
    rt_sel      = '0;
    rs_load_use = 1'b0;
    rt_load_use = 1'b0;
    for (int k = PIPE_DEPTH - 1; k >= 1; k--) begin
      if (slot_v[k] && slot_rw[k] && (slot_dest[k] == id_rs) && (id_rs != '0)) begin
        rs_sel      = SEL_W'(k + 1);
        rs_load_use = slot_mr[k] && ((k + 1) < LOAD_AVAIL);
      end
      if (slot_v[k] && slot_rw[k] && (slot_dest[k] == id_rt) && (id_rt != '0)) begin
        rt_sel      = SEL_W'(k + 1);
        rt_load_use = slot_mr[k] && ((k + 1) < LOAD_AVAIL);
      end
    end
  end

  assign stall = id_valid && running && !flush && (rs_load_use || (rt_load_use && id_uses_rt));
  assign issue = id_valid && running && !flush && !stall && !id_halt;
  assign slot_valid = slot_v;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_v  <= '0;
      slot_rw <= '0;
      slot_mr <= '0;
      for (int k = 1; k <= PIPE_DEPTH; k++) slot_dest[k] <= '0;
    end else begin
      slot_v[1]    <= issue;
      slot_rw[1]   <= issue && id_reg_write;
      slot_mr[1]   <= issue && id_mem_read;
      slot_dest[1] <= id_dest;
      for (int k = 2; k <= PIPE_DEPTH; k++) begin
        slot_v[k]    <= slot_v[k-1];
        slot_rw[k]   <= slot_rw[k-1];
        slot_mr[k]   <= slot_mr[k-1];
        slot_dest[k] <= slot_dest[k-1];
      end
      // The record leaving slot 1 is the branch's wrong-path instruction.
      if (flush) slot_v[2] <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_fwd_rs_sel <= '0;
      ex_fwd_rt_sel <= '0;
      stall_count   <= '0;
      issue_count   <= '0;
    end else begin
      ex_fwd_rs_sel <= issue ? rs_sel : '0;
      ex_fwd_rt_sel <= issue ? rt_sel : '0;
      if (stall && (stall_count != '1)) stall_count <= stall_count + 1'b1;
      if (issue && (issue_count != '1)) issue_count <= issue_count + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == ST_RUN) drain_cnt <= SEL_W'(PIPE_DEPTH);
      else if (state == ST_DRAIN) drain_cnt <= drain_cnt - 1'b1;
    end
  end

  // Leaving DRAIN as the counter reaches zero gives halted PIPE_DEPTH+1 edges after halt.
  always_comb begin
    next_state = state;
    case (state)
      ST_RUN:    if (id_valid && id_halt && !stall && !flush) next_state = ST_DRAIN;
      ST_DRAIN:  if (drain_cnt == SEL_W'(1)) next_state = ST_HALTED;
      ST_HALTED: next_state = ST_HALTED;
      default:   next_state = ST_RUN;
    endcase
  end

  always_comb begin
    running = (state == ST_RUN);
    halted  = (state == ST_HALTED);
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_hazard_unit
// Purpose  : Scoreboard bench for mips_hazard_unit (default and deep pipeline).
// Revision : 1.0
// ============================================================================
module tb_mips_hazard_unit;

  typedef struct {
    string nm;
    int st, is, rss, rts, sv, hl, sc, ic;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // DUT 0: default parameters
  logic rn0 = 1'b0, v0 = 1'b0, h0 = 1'b0, u0 = 1'b0, rw0 = 1'b0, mr0 = 1'b0, fl0 = 1'b0;
  logic [4:0] rs0 = '0, rt0 = '0, d0 = '0;
  logic st0, is0, hl0;
  logic [1:0] rss0, rts0;
  logic [2:0] sv0;
  logic [15:0] sc0, ic0;

  // DUT 1: PIPE_DEPTH=5, LOAD_AVAIL=4, CNT_W=2
  logic rn1 = 1'b0, v1 = 1'b0, h1 = 1'b0, u1 = 1'b0, rw1 = 1'b0, mr1 = 1'b0, fl1 = 1'b0;
  logic [4:0] rs1 = '0, rt1 = '0, d1 = '0;
  logic st1, is1, hl1;
  logic [2:0] rss1, rts1;
  logic [4:0] sv1;
  logic [1:0] sc1, ic1;

  mips_hazard_unit u_dut0 (
    .clock(clock), .reset_n(rn0), .id_valid(v0), .id_halt(h0), .id_rs(rs0), .id_rt(rt0),
    .id_uses_rt(u0), .id_dest(d0), .id_reg_write(rw0), .id_mem_read(mr0), .flush(fl0),
    .stall(st0), .issue(is0), .ex_fwd_rs_sel(rss0), .ex_fwd_rt_sel(rts0), .slot_valid(sv0),
    .halted(hl0), .stall_count(sc0), .issue_count(ic0)
  );

  mips_hazard_unit #(.PIPE_DEPTH(5), .LOAD_AVAIL(4), .CNT_W(2)) u_dut1 (
    .clock(clock), .reset_n(rn1), .id_valid(v1), .id_halt(h1), .id_rs(rs1), .id_rt(rt1),
    .id_uses_rt(u1), .id_dest(d1), .id_reg_write(rw1), .id_mem_read(mr1), .flush(fl1),
    .stall(st1), .issue(is1), .ex_fwd_rs_sel(rss1), .ex_fwd_rt_sel(rts1), .slot_valid(sv1),
    .halted(hl1), .stall_count(sc1), .issue_count(ic1)
  );

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int checks = 0;
  int passes = 0;

  task automatic check(string nm, string f, int act, int exp);
    if (exp < 0) return;
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s.%s: got %0d expected %0d", nm, f, act, exp);
  endtask

  // One cycle: drive inputs after the edge and queue what the DUT must show this cycle.
  task automatic step(int u, string nm, int rn, int v, int h, int rs, int rt, int us, int d,
                      int rw, int mr, int fl, int st, int is, int rss, int rts, int sv,
                      int hl, int sc, int ic);
    exp_t e;
    @(posedge clock);
    #1;
    if (u == 0) begin
      rn0 = rn[0]; v0 = v[0]; h0 = h[0]; rs0 = rs[4:0]; rt0 = rt[4:0]; u0 = us[0];
      d0 = d[4:0]; rw0 = rw[0]; mr0 = mr[0]; fl0 = fl[0];
    end else begin
      rn1 = rn[0]; v1 = v[0]; h1 = h[0]; rs1 = rs[4:0]; rt1 = rt[4:0]; u1 = us[0];
      d1 = d[4:0]; rw1 = rw[0]; mr1 = mr[0]; fl1 = fl[0];
    end
    e.nm = nm; e.st = st; e.is = is; e.rss = rss; e.rts = rts;
    e.sv = sv; e.hl = hl; e.sc = sc; e.ic = ic;
    if (u == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  always @(negedge clock) begin
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      check(e0.nm, "stall", int'(st0), e0.st);
      check(e0.nm, "issue", int'(is0), e0.is);
      check(e0.nm, "rs_sel", int'(rss0), e0.rss);
      check(e0.nm, "rt_sel", int'(rts0), e0.rts);
      check(e0.nm, "slot_valid", int'(sv0), e0.sv);
      check(e0.nm, "halted", int'(hl0), e0.hl);
      check(e0.nm, "stall_count", int'(sc0), e0.sc);
      check(e0.nm, "issue_count", int'(ic0), e0.ic);
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      check(e1.nm, "stall", int'(st1), e1.st);
      check(e1.nm, "issue", int'(is1), e1.is);
      check(e1.nm, "rs_sel", int'(rss1), e1.rss);
      check(e1.nm, "rt_sel", int'(rts1), e1.rts);
      check(e1.nm, "slot_valid", int'(sv1), e1.sv);
      check(e1.nm, "halted", int'(hl1), e1.hl);
      check(e1.nm, "stall_count", int'(sc1), e1.sc);
      check(e1.nm, "issue_count", int'(ic1), e1.ic);
    end
  end

  task automatic run0();
    //        nm     rn v h rs rt u  d rw mr fl | st is rss rts sv hl sc ic
    step(0, "rst",   0, 0,0, 0, 0,0, 0, 0,0,0,   0, 0, 0, 0, 0, 0, 0, 0);
    step(0, "rel",   1, 0,0, 0, 0,0, 0, 0,0,0,   0, 0, 0, 0, 0, 0, 0, 0);
    step(0, "A1lw",  1, 1,0, 1, 2,0, 2, 1,1,0,   0, 1, 0, 0, 0, 0, 0, 0);
    step(0, "A2add", 1, 1,0, 2, 4,1, 3, 1,0,0,   1, 0, 0, 0, 1, 0, 0, 1);
    step(0, "A3add", 1, 1,0, 2, 4,1, 3, 1,0,0,   0, 1, 0, 0, 2, 0, 1, 1);
    step(0, "A4",    1, 0,0, 0, 0,0, 0, 0,0,0,   0, 0, 3, 0, 5, 0, 1, 2);
    step(0, "A5",    1, 0,0, 0, 0,0, 0, 0,0,0,   0, 0, 0, 0, 2, 0, 1, 2);
    step(0, "A6",    1, 0,0, 0, 0,0, 0, 0,0,0,   0, 0, 0, 0, 4, 0, 1, 2);
    step(0, "B1add", 1, 1,0, 1, 1,1, 5, 1,0,0,   0, 1, 0, 0, 0, 0, 1, 2);
    step(0, "B2sub", 1, 1,0, 5, 5,1, 6, 1,0,0,   0, 1, 0, 0, 1, 0, 1, 3);
    step(0, "B3",    1, 0,0, 0, 0,0, 0, 0,0,0,   0, 0, 2, 2, 3, 0, 1, 4);
    step(0, "B4",    1, 0,0, 0, 0,0, 0, 0,0,0,   0, 0, 0, 0, 6, 0, 1, 4);
    step(0, "B5",    1, 0,0, 0, 0,0, 0, 0,0,0,   0, 0, 0, 0, 4, 0, 1, 4);
    step(0, "C1p1",  1, 1,0, 1, 1,1, 7, 1,0,0,   0, 1, 0, 0, 0, 0, 1, 4);
    step(0, "C2p2",  1, 1,0, 1, 1,1, 7, 1,0,0,   0, 1, 0, 0, 1, 0, 1, 5);
    step(0, "C3use", 1, 1,0, 7, 0,1, 8, 1,0,0,   0, 1, 0, 0, 3, 0, 1, 6);
    step(0, "C4lw0", 1, 1,0, 1, 0,0, 0, 1,1,0,   0, 1, 2, 0, 7, 0, 1, 7);
    step(0, "C5r0",  1, 1,0, 0, 0,1, 9, 1,0,0,   0, 1, 0, 0, 7, 0, 1, 8);
    step(0, "C6",    1, 0,0, 0, 0,0, 0, 0,0,0,   0, 0, 0, 0, 7, 0, 1, 9);
    step(0, "C7",    1, 0,0, 0, 0,0, 0, 0,0,0,   0, 0, 0, 0, 6, 0, 1, 9);
    step(0, "C8",    1, 0,0, 0, 0,0, 0, 0,0,0,   0, 0, 0, 0, 4, 0, 1, 9);
    step(0, "D1lw",  1, 1,0, 1, 0,0,10, 1,1,0,   0, 1, 0, 0, 0, 0, 1, 9);
    step(0, "D2fl",  1, 1,0,10,10,1,11, 1,0,1,   0, 0, 0, 0, 1, 0, 1,10);
    step(0, "D3",    1, 0,0, 0, 0,0, 0, 0,0,0,   0, 0, 0, 0, 0, 0, 1,10);
    step(0, "E1",    1, 1,0, 1, 1,1,12, 1,0,0,   0, 1, 0, 0, 0, 0, 1,10);
    step(0, "E2",    1, 1,0, 1, 1,1,13, 1,0,0,   0, 1, 0, 0, 1, 0, 1,11);
    step(0, "E3halt",1, 1,1,31,31,1,31, 0,0,0,   0, 0, 0, 0, 3, 0, 1,12);
    step(0, "E4dr",  1, 1,0, 1, 1,1,14, 1,0,0,   0, 0, 0, 0, 6, 0, 1,12);
    step(0, "E5dr",  1, 1,0, 1, 1,1,14, 1,0,0,   0, 0, 0, 0, 4, 0, 1,12);
    step(0, "E6dr",  1, 1,0, 1, 1,1,14, 1,0,0,   0, 0, 0, 0, 0, 0, 1,12);
    step(0, "E7hlt", 1, 1,0, 1, 1,1,14, 1,0,0,   0, 0, 0, 0, 0, 1, 1,12);
    step(0, "E8hlt", 1, 1,0, 1, 1,1,14, 1,0,0,   0, 0, 0, 0, 0, 1, 1,12);
    step(0, "F1rst", 0, 0,0, 0, 0,0, 0, 0,0,0,   0, 0, 0, 0, 0, 0, 0, 0);
    step(0, "F2rel", 1, 0,0, 0, 0,0, 0, 0,0,0,   0, 0, 0, 0, 0, 0, 0, 0);
    step(0, "F3add", 1, 1,0, 1, 1,1,14, 1,0,0,   0, 1, 0, 0, 0, 0, 0, 0);
    step(0, "F4halt",1, 1,1,31,31,1,31, 0,0,0,   0, 0, 0, 0, 1, 0, 0, 1);
    step(0, "F5dr",  1, 1,0, 1, 1,1,15, 1,0,0,   0, 0, 0, 0, 2, 0, 0, 1);
    step(0, "F6rst", 0, 0,0, 0, 0,0, 0, 0,0,0,   0, 0, 0, 0, 0, 0, 0, 0);
    step(0, "F7run", 1, 1,0, 1, 1,1,15, 1,0,0,   0, 1, 0, 0, 0, 0, 0, 0);
    step(0, "F8",    1, 0,0, 0, 0,0, 0, 0,0,0,   0, 0, 0, 0, 1, 0, 0, 1);
  endtask

  task automatic run1();
    //        nm     rn v h rs rt u  d rw mr fl | st is rss rts  sv hl sc ic
    step(1, "rst",   0, 0,0, 0, 0,0, 0, 0,0,0,   0, 0, 0, 0,  0, 0, 0, 0);
    step(1, "rel",   1, 0,0, 0, 0,0, 0, 0,0,0,   0, 0, 0, 0,  0, 0, 0, 0);
    step(1, "G1lw",  1, 1,0, 1, 2,0, 2, 1,1,0,   0, 1, 0, 0,  0, 0, 0, 0);
    step(1, "G2add", 1, 1,0, 2, 4,1, 3, 1,0,0,   1, 0, 0, 0,  1, 0, 0, 1);
    step(1, "G3add", 1, 1,0, 2, 4,1, 3, 1,0,0,   1, 0, 0, 0,  2, 0, 1, 1);
    step(1, "G4add", 1, 1,0, 2, 4,1, 3, 1,0,0,   0, 1, 0, 0,  4, 0, 2, 1);
    step(1, "G5",    1, 0,0, 0, 0,0, 0, 0,0,0,   0, 0, 4, 0,  9, 0, 2, 2);
    step(1, "G6lw",  1, 1,0, 1, 0,0, 5, 1,1,0,   0, 1, 0, 0, 18, 0, 2, 2);
    step(1, "G7use", 1, 1,0, 0, 5,1, 7, 1,0,0,   1, 0, 0, 0,  5, 0, 2, 3);
    step(1, "G8use", 1, 1,0, 0, 5,1, 7, 1,0,0,   1, 0, 0, 0, 10, 0, 3, 3);
    step(1, "G9use", 1, 1,0, 0, 5,1, 7, 1,0,0,   0, 1, 0, 0, 20, 0, 3, 3);
    step(1, "G10",   1, 0,0, 0, 0,0, 0, 0,0,0,   0, 0, 0, 4,  9, 0, 3, 3);
    step(1, "G11lw", 1, 1,0, 1, 0,0, 6, 1,1,0,   0, 1, 0, 0, -1, 0, 3, 3);
    step(1, "G12nrt",1, 1,0, 0, 6,0, 8, 1,0,0,   0, 1, 0, 0, -1, 0, 3, 3);
    step(1, "G13use",1, 1,0, 6, 0,1, 9, 1,0,0,   1, 0, 0,-1, -1, 0, 3, 3);
    step(1, "G14use",1, 1,0, 6, 0,1, 9, 1,0,0,   0, 1, 0, 0, -1, 0, 3, 3);
    step(1, "G15",   1, 0,0, 0, 0,0, 0, 0,0,0,   0, 0, 4, 0, -1, 0, 3, 3);
  endtask

  initial begin
    fork
      run0();
      run1();
    join
    repeat (3) @(posedge clock);
    check("end", "q0_pending", q0.size(), 0);
    check("end", "q1_pending", q1.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
